// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bus between the EX stage and the multi-cycle
// multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Op;
  logic [WIDTH-1:0] DataA;
  logic [WIDTH-1:0] DataB;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, DataA, DataB,
    input  Busy, Done, DivZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, DataA, DataB,
    output Busy, Done, DivZero, Hi, Lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU unit: one shared 32-bit ALU iterated 32
// times (shift-add multiply, restoring divide), results held in HI/LO.
module muldiv_alu32 (
  input  logic [2:0]  ctl_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] y_o
);
  always_comb begin
    y_o = '0;
    unique case (ctl_i)
      3'b000:  y_o = a_i & b_i;
      3'b001:  y_o = a_i | b_i;
      3'b010:  y_o = a_i + b_i;
      3'b110:  y_o = a_i - b_i;
      3'b011:  y_o = b_i << shamt_i;
      3'b111:  y_o = {31'b0, ($signed(a_i) < $signed(b_i))};
      default: y_o = '0;
    endcase
  end
endmodule

module muldiv_sequencer #(
  parameter int WIDTH = 32  // the shared ALU is 32 bits wide; only 32 works
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] whi_q, whi_d;
  logic [WIDTH-1:0] wlo_q, wlo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  logic [2:0]       alu_ctl;
  logic [31:0]      alu_a, alu_b, alu_y;
  logic             div_t, div_k, mul_c, last_iter;
  logic [WIDTH-1:0] div_r, div_q;

  muldiv_alu32 u_alu (
    .ctl_i   (alu_ctl),
    .a_i     (alu_a),
    .b_i     (alu_b),
    .shamt_i (5'd0),
    .y_o     (alu_y)
  );

  // Carry/no-borrow are rebuilt from the operand and result MSBs because
  // the ALU exposes no carry-out.
  assign div_t     = whi_q[WIDTH-1];
  assign div_r     = {whi_q[WIDTH-2:0], wlo_q[WIDTH-1]};
  assign div_q     = {wlo_q[WIDTH-2:0], 1'b0};
  assign mul_c     = (whi_q[WIDTH-1] & b_q[WIDTH-1]) |
                     ((whi_q[WIDTH-1] | b_q[WIDTH-1]) & ~alu_y[WIDTH-1]);
  assign div_k     = (div_r[WIDTH-1] & ~b_q[WIDTH-1]) |
                     ((div_r[WIDTH-1] | ~b_q[WIDTH-1]) & ~alu_y[WIDTH-1]);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      whi_q   <= '0;
      wlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      whi_q   <= whi_d;
      wlo_q   <= wlo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    whi_d   = whi_q;
    wlo_d   = wlo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          b_d   = bus.DataB;
          cnt_d = '0;
          if (!bus.Op || (bus.DataB != '0)) begin
            whi_d   = '0;
            wlo_d   = bus.DataA;
            state_d = bus.Op ? DIV : MUL;
          end else begin
            hi_d    = bus.DataA;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (wlo_q[0]) {whi_d, wlo_d} = {mul_c, alu_y, wlo_q[WIDTH-1:1]};
        else          {whi_d, wlo_d} = {1'b0, whi_q, wlo_q[WIDTH-1:1]};
        if (last_iter) begin
          hi_d    = whi_d;
          lo_d    = wlo_d;
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end
      DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (div_t | div_k) begin
          whi_d = alu_y;
          wlo_d = {div_q[WIDTH-1:1], 1'b1};
        end else begin
          whi_d = div_r;
          wlo_d = div_q;
        end
        if (last_iter) begin
          hi_d    = whi_d;
          lo_d    = wlo_d;
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_ctl  = 3'b010;
    alu_a    = '0;
    alu_b    = '0;
    bus.Busy = 1'b0;
    bus.Done = 1'b0;
    unique case (state_q)
      MUL: begin
        alu_a    = whi_q;
        alu_b    = b_q;
        bus.Busy = 1'b1;
      end
      DIV: begin
        alu_ctl  = 3'b110;
        alu_a    = div_r;
        alu_b    = b_q;
        bus.Busy = 1'b1;
      end
      DONE:    bus.Done = 1'b1;
      default: ;
    endcase
  end

  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;
  assign bus.DivZero = dz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, divide-by-zero,
// ignored Start pulses and asynchronous reset mid-operation.
module tb_muldiv_sequencer;
  logic clk;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation and checks latency, busy length, results and the
  // single Done pulse. With inject set, Start is pulsed with other operands
  // during Busy and again while Done is high.
  task automatic run_op(input string tag, input logic op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz, input int exp_lat, input int exp_busy,
                        input bit inject);
    int lat;
    int busy_n;
    lat    = 0;
    busy_n = 0;
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.DataA = a;
    bus.DataB = b;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.DataA = ~a;
    bus.DataB = ~b;
    for (int i = 1; i <= 40; i++) begin
      if (bus.Done) begin
        lat = i;
        break;
      end
      if (bus.Busy) busy_n++;
      if (inject) begin
        bus.Start = (i == 10);
        bus.Op    = ~op;
      end
      @(negedge clk);
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".busy_cycles"}, busy_n, exp_busy);
    chk({tag, ".hi"}, bus.Hi, exp_hi);
    chk({tag, ".lo"}, bus.Lo, exp_lo);
    chk({tag, ".divzero"}, {31'b0, bus.DivZero}, {31'b0, exp_dz});
    if (inject) bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    chk({tag, ".done_one_cycle"}, {31'b0, bus.Done}, 32'd0);
    chk({tag, ".idle_busy"}, {31'b0, bus.Busy}, 32'd0);
    @(negedge clk);
    chk({tag, ".no_restart"}, {31'b0, bus.Busy}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.Start = 1'b0;
    bus.Op    = 1'b0;
    bus.DataA = '0;
    bus.DataB = '0;
    repeat (2) @(negedge clk);
    chk("reset.busy", {31'b0, bus.Busy}, 32'd0);
    chk("reset.done", {31'b0, bus.Done}, 32'd0);
    chk("reset.divzero", {31'b0, bus.DivZero}, 32'd0);
    chk("reset.hi", bus.Hi, 32'd0);
    chk("reset.lo", bus.Lo, 32'd0);
    rst = 1'b0;

    run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33, 32, 1'b0);
    run_op("mul_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 32, 1'b0);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 32, 1'b0);
    run_op("div_max_1", 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 33, 32, 1'b0);
    run_op("div_msb", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33, 32, 1'b0);
    run_op("div_by_0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1, 0, 1'b0);
    run_op("mul_2x3", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, 32, 1'b0);
    run_op("ignored_start", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'hFFFFFFF0, 1'b0, 33, 32, 1'b1);

    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = 1'b0;
    bus.DataA = 32'h12345678;
    bus.DataB = 32'h9ABCDEF0;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort.busy_before", {31'b0, bus.Busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort.busy", {31'b0, bus.Busy}, 32'd0);
    chk("abort.done", {31'b0, bus.Done}, 32'd0);
    chk("abort.hi", bus.Hi, 32'd0);
    chk("abort.lo", bus.Lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul_3x4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 32, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
